// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: shares one memory port between the I-cache and the D-cache.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin instead of D-first priority.
module sys_bus_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 32,
    parameter int BURSTLEN  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 I_SYSstrobe,
    input  logic                 I_SYSrw,
    input  logic [ADDRWIDTH-1:0] I_SYSaddr,
    input  logic [DATAWIDTH-1:0] I_SYSdata_out,
    output logic                 I_SYSready,
    output logic [DATAWIDTH-1:0] I_SYSdata_in,
    input  logic                 D_SYSstrobe,
    input  logic                 D_SYSrw,
    input  logic [ADDRWIDTH-1:0] D_SYSaddr,
    input  logic [DATAWIDTH-1:0] D_SYSdata_out,
    output logic                 D_SYSready,
    output logic [DATAWIDTH-1:0] D_SYSdata_in,
    output logic                 MEM_strobe,
    output logic                 MEM_rw,
    output logic [ADDRWIDTH-1:0] MEM_addr,
    output logic [DATAWIDTH-1:0] MEM_data_out,
    input  logic                 MEM_ready,
    input  logic [DATAWIDTH-1:0] MEM_data_in,
    output logic [1:0]           grant
);

    localparam int BW = (BURSTLEN > 1) ? $clog2(BURSTLEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_I = 2'd1,
        S_OWN_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_grant;
    logic [BW-1:0] r_beat;
    logic [BW-1:0] w_beat_next;
    logic          w_own_strobe;
    logic          w_last_beat;
    logic          w_pick_d;

    assign w_last_beat = (r_beat == BW'(BURSTLEN - 1));
    assign grant       = r_grant;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 = I-cache was the most recent owner, 1 = D-cache
    logic r_last;

    // Remember who was granted last so a tie goes to the other cache
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (r_state == S_IDLE && w_next == S_OWN_D) begin
            r_last <= 1'b1;
        end else if (r_state == S_IDLE && w_next == S_OWN_I) begin
            r_last <= 1'b0;
        end
    end

    assign w_pick_d = ~r_last;
`else
    assign w_pick_d = 1'b1;
`endif

    // State, grant and beat counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            r_grant <= {w_next == S_OWN_D, w_next == S_OWN_I};
            r_beat  <= w_beat_next;
        end
    end

    // Next-state: arbitrate in IDLE, hold the lock until strobe drop or last beat
    always_comb begin
        w_next       = r_state;
        w_beat_next  = r_beat;
        w_own_strobe = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_beat_next = '0;
                if (I_SYSstrobe && D_SYSstrobe) begin
                    w_next = w_pick_d ? S_OWN_D : S_OWN_I;
                end else if (D_SYSstrobe) begin
                    w_next = S_OWN_D;
                end else if (I_SYSstrobe) begin
                    w_next = S_OWN_I;
                end
            end
            S_OWN_I, S_OWN_D: begin
                w_own_strobe = (r_state == S_OWN_I) ? I_SYSstrobe : D_SYSstrobe;
                if (!w_own_strobe) begin
                    w_next      = S_IDLE;
                    w_beat_next = '0;
                end else if (MEM_ready) begin
                    if (w_last_beat) begin
                        w_next      = S_IDLE;
                        w_beat_next = '0;
                    end else begin
                        w_beat_next = r_beat + BW'(1);
                    end
                end
            end
            default: begin
                w_next      = S_IDLE;
                w_beat_next = '0;
            end
        endcase
    end

    // Forward the owner to memory; everything is quiet while idle
    always_comb begin
        MEM_strobe   = 1'b0;
        MEM_rw       = 1'b0;
        MEM_addr     = '0;
        MEM_data_out = '0;
        I_SYSready   = 1'b0;
        I_SYSdata_in = '0;
        D_SYSready   = 1'b0;
        D_SYSdata_in = '0;
        unique case (r_state)
            S_OWN_I: begin
                MEM_strobe   = I_SYSstrobe;
                MEM_rw       = I_SYSrw;
                MEM_addr     = I_SYSaddr;
                MEM_data_out = I_SYSdata_out;
                I_SYSready   = MEM_ready;
                I_SYSdata_in = MEM_data_in;
            end
            S_OWN_D: begin
                MEM_strobe   = D_SYSstrobe;
                MEM_rw       = D_SYSrw;
                MEM_addr     = D_SYSaddr;
                MEM_data_out = D_SYSdata_out;
                D_SYSready   = MEM_ready;
                D_SYSdata_in = MEM_data_in;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: directed vector table plus hand sequences
// for burst arbitration, release bubble and async reset.
module tb_sys_bus_arbiter;

    localparam logic [31:0] IA  = 32'h0000_1000;
    localparam logic [31:0] DA  = 32'h0000_2000;
    localparam logic [31:0] IDO = 32'h1111_1111;
    localparam logic [31:0] DDO = 32'h2222_2222;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        I_SYSstrobe = 1'b0;
    logic        I_SYSrw = 1'b0;
    logic [31:0] I_SYSaddr;
    logic [31:0] I_SYSdata_out;
    logic        I_SYSready;
    logic [31:0] I_SYSdata_in;
    logic        D_SYSstrobe = 1'b0;
    logic        D_SYSrw = 1'b0;
    logic [31:0] D_SYSaddr;
    logic [31:0] D_SYSdata_out;
    logic        D_SYSready;
    logic [31:0] D_SYSdata_in;
    logic        MEM_strobe;
    logic        MEM_rw;
    logic [31:0] MEM_addr;
    logic [31:0] MEM_data_out;
    logic        MEM_ready = 1'b0;
    logic [31:0] MEM_data_in = 32'h0;
    logic [1:0]  grant;

    int errs   = 0;
    int checks = 0;

    assign I_SYSaddr     = IA;
    assign I_SYSdata_out = IDO;
    assign D_SYSaddr     = DA;
    assign D_SYSdata_out = DDO;

    always #5 clk = ~clk;

    sys_bus_arbiter #(
        .DATAWIDTH(32),
        .ADDRWIDTH(32),
        .BURSTLEN (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .I_SYSstrobe  (I_SYSstrobe),
        .I_SYSrw      (I_SYSrw),
        .I_SYSaddr    (I_SYSaddr),
        .I_SYSdata_out(I_SYSdata_out),
        .I_SYSready   (I_SYSready),
        .I_SYSdata_in (I_SYSdata_in),
        .D_SYSstrobe  (D_SYSstrobe),
        .D_SYSrw      (D_SYSrw),
        .D_SYSaddr    (D_SYSaddr),
        .D_SYSdata_out(D_SYSdata_out),
        .D_SYSready   (D_SYSready),
        .D_SYSdata_in (D_SYSdata_in),
        .MEM_strobe   (MEM_strobe),
        .MEM_rw       (MEM_rw),
        .MEM_addr     (MEM_addr),
        .MEM_data_out (MEM_data_out),
        .MEM_ready    (MEM_ready),
        .MEM_data_in  (MEM_data_in),
        .grant        (grant)
    );

    typedef struct {
        logic        rst;
        logic        is;
        logic        irw;
        logic        ds;
        logic        drw;
        logic        mr;
        logic [31:0] mdi;
        logic [1:0]  g;
        logic        ms;
        logic        mrw;
        logic [31:0] ma;
        logic [31:0] mdo;
        logic        ir;
        logic        dr;
        logic [31:0] idin;
        logic [31:0] ddin;
    } vec_t;

    localparam int NV = 23;
    vec_t v [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] own [3];
        logic [1:0] eg;
        int         pulses;
        bit         done;

        //      rst is irw ds drw mr mdi            g     ms mrw ma  mdo  ir dr idin           ddin
        v[0]  = '{1, 1, 1, 1, 1, 0, 32'h0,          2'b00, 0, 0, 0,  0,   0, 0, 32'h0,         32'h0};
        v[1]  = '{1, 1, 1, 1, 1, 0, 32'h0,          2'b00, 0, 0, 0,  0,   0, 0, 32'h0,         32'h0};
        v[2]  = '{0, 1, 1, 1, 1, 0, 32'h0,          2'b00, 0, 0, 0,  0,   0, 0, 32'h0,         32'h0};
        v[3]  = '{0, 1, 1, 0, 1, 0, 32'h0,          2'b10, 0, 1, DA, DDO, 0, 0, 32'h0,         32'h0};
        v[4]  = '{0, 1, 1, 0, 1, 0, 32'h0,          2'b00, 0, 0, 0,  0,   0, 0, 32'h0,         32'h0};
        v[5]  = '{0, 1, 1, 0, 0, 0, 32'h0,          2'b01, 1, 1, IA, IDO, 0, 0, 32'h0,         32'h0};
        v[6]  = '{0, 1, 1, 0, 0, 1, 32'hA0A0_0000,  2'b01, 1, 1, IA, IDO, 1, 0, 32'hA0A0_0000, 32'h0};
        v[7]  = '{0, 1, 1, 0, 0, 0, 32'h0,          2'b01, 1, 1, IA, IDO, 0, 0, 32'h0,         32'h0};
        v[8]  = '{0, 1, 1, 0, 0, 1, 32'hA1A1_0001,  2'b01, 1, 1, IA, IDO, 1, 0, 32'hA1A1_0001, 32'h0};
        v[9]  = '{0, 1, 1, 0, 0, 0, 32'h0,          2'b01, 1, 1, IA, IDO, 0, 0, 32'h0,         32'h0};
        v[10] = '{0, 1, 1, 0, 0, 1, 32'hA2A2_0002,  2'b01, 1, 1, IA, IDO, 1, 0, 32'hA2A2_0002, 32'h0};
        v[11] = '{0, 1, 1, 0, 0, 0, 32'h0,          2'b01, 1, 1, IA, IDO, 0, 0, 32'h0,         32'h0};
        v[12] = '{0, 1, 1, 0, 0, 1, 32'hA3A3_0003,  2'b01, 1, 1, IA, IDO, 1, 0, 32'hA3A3_0003, 32'h0};
        v[13] = '{0, 0, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0,  0,   0, 0, 32'h0,         32'h0};
        v[14] = '{0, 0, 1, 0, 0, 1, 32'hDEADBEEF,   2'b00, 0, 0, 0,  0,   0, 0, 32'h0,         32'h0};
        v[15] = '{0, 1, 1, 1, 0, 0, 32'h0,          2'b00, 0, 0, 0,  0,   0, 0, 32'h0,         32'h0};
        v[16] = '{0, 1, 1, 1, 0, 0, 32'h0,          2'b10, 1, 0, DA, DDO, 0, 0, 32'h0,         32'h0};
        v[17] = '{0, 1, 1, 1, 0, 1, 32'h5555_5555,  2'b10, 1, 0, DA, DDO, 0, 1, 32'h0,         32'h5555_5555};
        v[18] = '{0, 1, 1, 0, 0, 0, 32'h0,          2'b10, 0, 0, DA, DDO, 0, 0, 32'h0,         32'h0};
        v[19] = '{0, 1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0,  0,   0, 0, 32'h0,         32'h0};
        v[20] = '{0, 1, 1, 0, 0, 0, 32'h0,          2'b01, 1, 1, IA, IDO, 0, 0, 32'h0,         32'h0};
        v[21] = '{0, 0, 1, 0, 0, 0, 32'h0,          2'b01, 0, 1, IA, IDO, 0, 0, 32'h0,         32'h0};
        v[22] = '{0, 0, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0,  0,   0, 0, 32'h0,         32'h0};

        #1 rst = 1'b1;
        I_SYSstrobe = 1'b1;
        D_SYSstrobe = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst         = v[i].rst;
            I_SYSstrobe = v[i].is;
            I_SYSrw     = v[i].irw;
            D_SYSstrobe = v[i].ds;
            D_SYSrw     = v[i].drw;
            MEM_ready   = v[i].mr;
            MEM_data_in = v[i].mdi;
            #1;
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(v[i].g));
            chk($sformatf("v%0d mem_strobe", i), 32'(MEM_strobe), 32'(v[i].ms));
            chk($sformatf("v%0d mem_rw", i), 32'(MEM_rw), 32'(v[i].mrw));
            chk($sformatf("v%0d mem_addr", i), MEM_addr, v[i].ma);
            chk($sformatf("v%0d mem_data_out", i), MEM_data_out, v[i].mdo);
            chk($sformatf("v%0d i_ready", i), 32'(I_SYSready), 32'(v[i].ir));
            chk($sformatf("v%0d d_ready", i), 32'(D_SYSready), 32'(v[i].dr));
            chk($sformatf("v%0d i_data_in", i), I_SYSdata_in, v[i].idin);
            chk($sformatf("v%0d d_data_in", i), D_SYSdata_in, v[i].ddin);
        end

        // Both caches hold their strobes for three back-to-back bursts
`ifdef ARB_ROUND_ROBIN_EN
        own[0] = 2'b10;
        own[1] = 2'b01;
        own[2] = 2'b10;
`else
        own[0] = 2'b10;
        own[1] = 2'b10;
        own[2] = 2'b10;
`endif
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 15) begin
                I_SYSstrobe = 1'b0;
                D_SYSstrobe = 1'b0;
                MEM_ready   = 1'b0;
            end else begin
                I_SYSstrobe = 1'b1;
                D_SYSstrobe = 1'b1;
                MEM_ready   = 1'b1;
            end
            MEM_data_in = 32'h0000_0C00 + 32'(c);
            #1;
            eg = (c % 5 == 0) ? 2'b00 : own[c / 5];
            chk($sformatf("rr c%0d grant", c), 32'(grant), 32'(eg));
            chk($sformatf("rr c%0d mem_strobe", c), 32'(MEM_strobe),
                32'(eg != 2'b00 && c != 15));
            chk($sformatf("rr c%0d i_ready", c), 32'(I_SYSready),
                32'(eg[0] & MEM_ready));
            chk($sformatf("rr c%0d d_ready", c), 32'(D_SYSready),
                32'(eg[1] & MEM_ready));
        end

        // Async reset in the middle of an I-cache burst
        @(negedge clk);
        I_SYSstrobe = 1'b1;
        I_SYSrw     = 1'b1;
        MEM_ready   = 1'b0;
        @(negedge clk);
        MEM_ready = 1'b1;
        #1;
        chk("rst_mid grant_before", 32'(grant), 32'(2'b01));
        @(negedge clk);
        MEM_ready = 1'b1;
        @(negedge clk);
        MEM_ready = 1'b0;
        #1;
        chk("rst_mid strobe_before", 32'(MEM_strobe), 32'(1'b1));
        #1 rst = 1'b1;
        #1;
        chk("rst_mid grant", 32'(grant), 32'(2'b00));
        chk("rst_mid mem_strobe", 32'(MEM_strobe), 32'(1'b0));
        chk("rst_mid mem_addr", MEM_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        done   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            MEM_ready   = 1'b1;
            MEM_data_in = 32'hB000_0000 + 32'(k);
            #1;
            if (grant == 2'b00) begin
                done = 1'b1;
                break;
            end
            if (I_SYSready) pulses++;
        end
        I_SYSstrobe = 1'b0;
        MEM_ready   = 1'b0;
        chk("fresh burst released", 32'(done), 32'(1'b1));
        chk("fresh burst beats", 32'(pulses), 32'd4);

        @(negedge clk);
        #1;
        chk("final grant", 32'(grant), 32'(2'b00));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
